gpio_port_ctrl: RTL and testbench

//   Parametrised GPIO port controller. Owns WIDTH bidirectional pins with per-pin direction.

---
 rtl/gpio_port_ctrl.sv | 158 +++++++++++++++
 tb/tb_gpio_port_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: WIDTH-pin GPIO port with per-pin direction, synchronised and
// edge-detected inputs, a sticky W1C interrupt status and a maskable level irq.
// Optional debounce filter: define GPIO_PORT_CTRL_DEBOUNCE_EN.
//
// Register bus handshake: wr_en is a single-cycle write strobe acting at the
// posedge where it is high. rd_en is a single-cycle read strobe. rd_valid
// pulses for one cycle on the following cycle with rd_data. rd_data holds its
// last value while rd_valid is low. There is no back-pressure.
module gpio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [2:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             irq,
    inout  wire  [WIDTH-1:0] gpio_pin
);

    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = $clog2(WARM + 1);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEB_CYCLES < 1) begin : g_bad_params
        $error("gpio_port_ctrl: parameter out of range");
    end

    logic [WIDTH-1:0] data_out, dir, irq_status, irq_mask, rise_en, fall_en;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] synced, in_q, in_prev, edge_set, w1c, rd_mux;
    logic [WW-1:0]    warm_cnt;
    logic             warm_done;

    // Pad drivers: a pin is driven only while its direction bit selects output.
    for (genvar g = 0; g < WIDTH; g++) begin : g_pad
        assign gpio_pin[g] = dir[g] ? data_out[g] : 1'bz;
    end

    // Input synchroniser chain; samples the pad, so output pins loop back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpio_pin;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_PORT_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] deb_cnt [WIDTH];

    // Debounce: accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
            for (int i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (synced[i] != in_q[i]) begin
                    if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                        in_q[i]    <= synced[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign in_q = synced;
`endif

    // Edge history and warm-up counter that masks reset-to-pad transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_prev  <= '0;
            warm_cnt <= '0;
        end else begin
            in_prev <= in_q;
            if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
        end
    end

    assign warm_done = (warm_cnt == WW'(WARM));

    // Edge qualification and W1C decode.
    always_comb begin
        edge_set = '0;
        w1c      = '0;
        if (warm_done) edge_set = (in_q & ~in_prev & rise_en) | (~in_q & in_prev & fall_en);
        if (wr_en && wr_addr == 3'd3) w1c = wr_data;
    end

    // Register file writes; a new edge wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            dir        <= '0;
            irq_status <= '0;
            irq_mask   <= '0;
            rise_en    <= '0;
            fall_en    <= '0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    3'd0:    data_out <= wr_data;
                    3'd1:    dir      <= wr_data;
                    3'd4:    irq_mask <= wr_data;
                    3'd5:    rise_en  <= wr_data;
                    3'd6:    fall_en  <= wr_data;
                    default: ;
                endcase
            end
            irq_status <= (irq_status & ~w1c) | edge_set;
        end
    end

    // Read mux over current (pre-write) register values.
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            3'd0:    rd_mux = data_out;
            3'd1:    rd_mux = dir;
            3'd2:    rd_mux = in_q;
            3'd3:    rd_mux = irq_status;
            3'd4:    rd_mux = irq_mask;
            3'd5:    rd_mux = rise_en;
            3'd6:    rd_mux = fall_en;
            default: rd_mux = '0;
        endcase
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

    assign irq = |(irq_status & irq_mask);

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb_gpio_port_ctrl: directed table, corner sequences and randomized traffic
// checked against a delay-line reference model of gpio_port_ctrl.
module tb_gpio_port_ctrl;

    localparam int W = 8;
    localparam int S = 2;
    localparam int D = 4;
`ifdef GPIO_PORT_CTRL_DEBOUNCE_EN
    localparam int LAT = S + D;
`else
    localparam int LAT = S;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         wr_en   = 1'b0;
    logic [2:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic         rd_en   = 1'b0;
    logic [2:0]   rd_addr = '0;
    wire  [W-1:0] rd_data;
    wire          rd_valid;
    wire          irq;
    wire  [W-1:0] gpio_pin;
    logic [W-1:0] tb_drv  = '0;
    logic [W-1:0] tb_oe   = '1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < W; g++) begin : g_tb_pad
        assign gpio_pin[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
    end

    gpio_port_ctrl #(.WIDTH(W), .SYNC_STAGES(S), .DEB_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq),
        .gpio_pin (gpio_pin)
    );

    // ---------------- reference model ----------------
    // pads[k] is the pad value sampled k+1 edges ago; DATA_IN is that value
    // SYNC_STAGES samples back and edges compare it with one sample earlier.
    logic [W-1:0] m_dout, m_dir, m_stat, m_mask, m_rise, m_fall, m_rdd;
    logic         m_rdv;
    logic [W-1:0] pads[$];
    int           since_rst;
    int           checks   = 0;
    int           failures = 0;

    function automatic logic [W-1:0] reg_val(input logic [2:0] a, input logic [W-1:0] din);
        case (a)
            3'd0:    return m_dout;
            3'd1:    return m_dir;
            3'd2:    return din;
            3'd3:    return m_stat;
            3'd4:    return m_mask;
            3'd5:    return m_rise;
            3'd6:    return m_fall;
            default: return '0;
        endcase
    endfunction

    task automatic model_tick();
        logic [W-1:0] pad, cur, prev, set, clr;
        pad = (m_dir & m_dout) | (~m_dir & tb_drv);
        if (rst) begin
            m_dout = '0; m_dir = '0; m_stat = '0; m_mask = '0;
            m_rise = '0; m_fall = '0; m_rdd = '0; m_rdv = 1'b0;
            pads.delete();
            for (int i = 0; i <= S; i++) pads.push_back('0);
            since_rst = 0;
        end else begin
            cur  = pads[S-1];
            prev = pads[S];
            set  = (since_rst > S) ? ((cur & ~prev & m_rise) | (~cur & prev & m_fall)) : '0;
            if (rd_en) m_rdd = reg_val(rd_addr, cur);
            m_rdv = rd_en;
            clr = (wr_en && wr_addr == 3'd3) ? wr_data : '0;
            if (wr_en) begin
                case (wr_addr)
                    3'd0:    m_dout = wr_data;
                    3'd1:    m_dir  = wr_data;
                    3'd4:    m_mask = wr_data;
                    3'd5:    m_rise = wr_data;
                    3'd6:    m_fall = wr_data;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | set;
            pads.push_front(pad);
            void'(pads.pop_back());
            if (since_rst < 1000) since_rst++;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: pins about to become outputs are pre-driven by the bench with
    // the value the DUT will drive, so the pad never sees a conflict.
    task automatic tick();
        if (!rst && wr_en && wr_addr == 3'd1)
            tb_drv = (tb_drv & ~wr_data) | (m_dout & wr_data);
        model_tick();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        tb_oe = ~m_dir;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [W-1:0] exp, input string name);
        rd_en = 1'b1; rd_addr = a;
        tick();
        chk({name, "_valid"}, rd_valid, 1);
        chk(name, rd_data, exp);
    endtask

    typedef struct {
        logic [2:0]   addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{3'd0, 8'h5A, 8'h5A};
        vecs[1] = '{3'd4, 8'h3C, 8'h3C};
        vecs[2] = '{3'd5, 8'h0F, 8'h0F};
        vecs[3] = '{3'd6, 8'hF0, 8'hF0};
        vecs[4] = '{3'd7, 8'hFF, 8'h00};
        vecs[5] = '{3'd3, 8'hFF, 8'h00};
        vecs[6] = '{3'd2, 8'h00, 8'h3C};

        // Reset and reset-state reads
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_irq", irq, 0);
        tb_drv = 8'h3C;
        idle(LAT + 1);
        for (int a = 0; a < 8; a++)
            rd_chk(3'(a), (a == 2) ? 8'h3C : 8'h00, $sformatf("rst_reg%0d", a));
        idle(4);
        rd_chk(3'd3, 8'h00, "rst_status_after_warmup");
        chk("rst_irq_after_warmup", irq, 0);

        // Register table: write then read back
        for (int i = 0; i < 7; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata);
            rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("tbl%0d", i));
        end

        // Same-cycle read and write return the pre-write value
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h11;
        rd_en = 1'b1; rd_addr = 3'd0;
        tick();
        chk("rdwr_same_cycle", rd_data, 8'h5A);
        rd_chk(3'd0, 8'h11, "rdwr_after");
        idle(2);
        chk("rd_valid_drops", rd_valid, 0);
        chk("rd_data_holds", rd_data, 8'h11);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(LAT + 1);

        // Direction and loopback
        do_write(3'd1, 8'hF0);
        tb_drv = (tb_drv & 8'hF0) | 8'h03;
        do_write(3'd0, 8'hA5);
        chk("pins_driven_hi", 32'(gpio_pin[7:4]), 4'hA);
        idle(LAT);
        rd_chk(3'd2, 8'hA3, "loopback_data_in");

        // Rising edge interrupt and W1C
        tb_drv = tb_drv & 8'hF0;
        idle(LAT + 2);
        do_write(3'd5, 8'h01);
        do_write(3'd4, 8'h01);
        tb_drv[0] = 1'b1;
        idle(LAT);
        chk("rise_irq_not_yet", irq, 0);
        tick();
        chk("rise_irq", irq, 1);
        rd_chk(3'd3, 8'h01, "rise_status");
        do_write(3'd3, 8'h01);
        chk("w1c_irq", irq, 0);
        rd_chk(3'd3, 8'h00, "w1c_status");

        // Falling edge, masking, and set-wins-over-clear
        tb_drv[1] = 1'b1;
        idle(LAT + 2);
        do_write(3'd6, 8'h02);
        do_write(3'd4, 8'h00);
        tb_drv[1] = 1'b0;
        idle(LAT + 1);
        rd_chk(3'd3, 8'h02, "fall_status");
        chk("fall_masked_irq", irq, 0);
        do_write(3'd4, 8'h02);
        chk("unmask_irq", irq, 1);
        tb_drv[1] = 1'b1;
        idle(LAT + 2);
        do_write(3'd3, 8'h02);
        chk("fall_clear_irq", irq, 0);
        tb_drv[1] = 1'b0;
        idle(LAT);
        do_write(3'd3, 8'h02);
        chk("set_wins_irq", irq, 1);
        rd_chk(3'd3, 8'h02, "set_wins_status");

        // Reset during a read; pins held high through reset
        do_write(3'd1, 8'h00);
        tb_drv = 8'hFF;
        idle(LAT + 2);
        rst = 1'b1; rd_en = 1'b1; rd_addr = 3'd4;
        tick();
        rst = 1'b0;
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_irq", irq, 0);
`ifndef GPIO_PORT_CTRL_DEBOUNCE_EN
        do_write(3'd5, 8'hFF);
        do_write(3'd6, 8'hFF);
`endif
        idle(LAT + 4);
        rd_chk(3'd3, 8'h00, "warmup_no_status");
        rd_chk(3'd0, 8'h00, "midrst_data_out");
        rd_chk(3'd1, 8'h00, "midrst_dir");
        rd_chk(3'd4, 8'h00, "midrst_mask");
        rd_chk(3'd2, 8'hFF, "midrst_data_in");

`ifdef GPIO_PORT_CTRL_DEBOUNCE_EN
        // Debounce: short pulse rejected, long pulse accepted once
        tb_drv = 8'hFB;
        idle(LAT + 2);
        do_write(3'd5, 8'h04);
        tb_drv[2] = 1'b1;
        idle(3);
        tb_drv[2] = 1'b0;
        idle(LAT + 4);
        rd_chk(3'd2, 8'hFB, "deb_glitch_data_in");
        rd_chk(3'd3, 8'h00, "deb_glitch_status");
        tb_drv[2] = 1'b1;
        idle(LAT);
        tb_drv[2] = 1'b0;
        rd_chk(3'd2, 8'hFF, "deb_accept_data_in");
        idle(LAT + 4);
        rd_chk(3'd3, 8'h04, "deb_accept_status");
        rd_chk(3'd2, 8'hFB, "deb_release_data_in");
`else
        // Randomized traffic against the reference model
        rst = 1'b1;
        tick();
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = W'($urandom);
            rd_en   = ($urandom_range(0, 1) == 1);
            rd_addr = 3'($urandom_range(0, 7));
            tb_drv  = tb_drv ^ W'($urandom & $urandom & $urandom);
            tick();
            chk("rand_rd_valid", rd_valid, m_rdv);
            chk("rand_rd_data", rd_data, m_rdd);
            chk("rand_irq", irq, |(m_stat & m_mask));
            chk("rand_pins", gpio_pin & m_dir, m_dout & m_dir);
        end
        rst = 1'b0;
        tick();
        rd_chk(3'd3, m_stat, "rand_final_status");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
